// File: rtl/fetch_controller.sv
// rtl/fetch_controller.sv - instruction fetch sequencer with req/gnt memory port, word buffer and redirect
//
// Owns the fetch PC, keeps at most one memory request in flight, buffers
// returned words in a small FIFO and hands {pc, instruction} to decode.
// Redirects flush the buffer and retire any in-flight word through DISCARD.
//
// Ports:
//   clk, reset_n                  clock, synchronous active-low reset
//   imem_req/addr/gnt             request side of the instruction memory port
//   imem_rvalid/rdata             response side, one response per issued request
//   redirect_valid/pc             branch/jump/trap target, low two bits ignored
//   inst_valid/ready/pc/data      head of the instruction buffer toward decode
module fetch_controller #(
    parameter logic [31:0] RESET_PC   = 32'h0000_0000,
    parameter int          FIFO_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        inst_valid,
    input  logic        inst_ready,
    output logic [31:0] inst_pc,
    output logic [31:0] inst_data
);

    localparam int          PW      = $clog2(FIFO_DEPTH);
    localparam int          CW      = $clog2(FIFO_DEPTH + 1);
    localparam logic [CW:0] DEPTH_W = (CW + 1)'(FIFO_DEPTH);

    typedef enum logic {
        ST_RUN     = 1'b0,
        ST_DISCARD = 1'b1
    } state_t;

    state_t        r_state;
    logic [31:0]   r_fetch_pc;
    logic [31:0]   r_out_pc;
    logic          r_outstanding;
    logic [31:0]   r_buf_pc   [FIFO_DEPTH];
    logic [31:0]   r_buf_data [FIFO_DEPTH];
    logic [PW-1:0] r_rd_ptr;
    logic [PW-1:0] r_wr_ptr;
    logic [CW-1:0] r_count;

    logic          w_pop;
    logic          w_push;
    logic          w_req;
    logic          w_issue;
    logic [CW:0]   w_occ;
    logic [31:0]   w_redirect_aligned;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        ptr_inc = (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    assign w_redirect_aligned = redirect_pc & ~32'd3;

    assign w_pop  = (r_count != '0) && inst_ready;
    assign w_push = (r_state == ST_RUN) && r_outstanding && imem_rvalid && !redirect_valid;

    // Slots that stay committed after this cycle: buffered words plus the
    // in-flight one (a retiring rvalid just moves it from flight into the
    // buffer), minus the word decode takes now. A new request needs one more.
    assign w_occ = {1'b0, r_count} + (CW + 1)'(r_outstanding) - (CW + 1)'(w_pop);

    // Single outstanding request: a new one may only go out once the previous
    // one is retiring in this same cycle.
    assign w_req   = (r_state == ST_RUN) && !redirect_valid
                  && (!r_outstanding || imem_rvalid) && (w_occ < DEPTH_W);
    assign w_issue = w_req && imem_gnt;

    assign imem_req   = w_req;
    assign imem_addr  = r_fetch_pc;
    assign inst_valid = (r_count != '0);
    assign inst_pc    = r_buf_pc[r_rd_ptr];
    assign inst_data  = r_buf_data[r_rd_ptr];

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            r_state       <= ST_RUN;
            r_fetch_pc    <= RESET_PC;
            r_out_pc      <= '0;
            r_outstanding <= 1'b0;
            r_rd_ptr      <= '0;
            r_wr_ptr      <= '0;
            r_count       <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_buf_pc[i]   <= '0;
                r_buf_data[i] <= '0;
            end
        end else if (redirect_valid) begin
            r_fetch_pc <= w_redirect_aligned;
            r_rd_ptr   <= '0;
            r_wr_ptr   <= '0;
            r_count    <= '0;
            // No request issues during a redirect, so the only word that can
            // still come back is one already in flight and not returning now.
            if (r_outstanding && !imem_rvalid) begin
                r_state       <= ST_DISCARD;
                r_outstanding <= 1'b1;
            end else begin
                r_state       <= ST_RUN;
                r_outstanding <= 1'b0;
            end
        end else begin
            if (w_issue) begin
                r_outstanding <= 1'b1;
                r_out_pc      <= r_fetch_pc;
                r_fetch_pc    <= r_fetch_pc + 32'd4;
            end else if (imem_rvalid) begin
                r_outstanding <= 1'b0;
            end

            if ((r_state == ST_DISCARD) && imem_rvalid) begin
                r_state <= ST_RUN;
            end

            if (w_push) begin
                r_buf_pc[r_wr_ptr]   <= r_out_pc;
                r_buf_data[r_wr_ptr] <= imem_rdata;
                r_wr_ptr             <= ptr_inc(r_wr_ptr);
            end
            if (w_pop) begin
                r_rd_ptr <= ptr_inc(r_rd_ptr);
            end

            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    a_no_overflow: assert property (@(posedge clk) disable iff (!reset_n)
        !(w_push && !w_pop && (r_count == CW'(FIFO_DEPTH))));

endmodule

// File: tb/tb_fetch_controller.sv
// tb/tb_fetch_controller.sv - self-checking bench for fetch_controller
module tb_fetch_controller;

    localparam logic [31:0] RST_PC = 32'hFFFF_FFF8;
    localparam int          DEPTH  = 2;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic [31:0] inst_pc;
    logic [31:0] inst_data;

    fetch_controller #(.RESET_PC(RST_PC), .FIFO_DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_gnt       (imem_gnt),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .inst_pc        (inst_pc),
        .inst_data      (inst_data)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Environment knobs
    int gnt_pct   = 100;
    int ready_pct = 100;
    int lat_min   = 1;
    int lat_max   = 1;
    bit force_stale = 1'b0;

    // Instruction memory: word at address a is ~a; one response per issue
    bit          m_busy = 1'b0;
    int          m_wait = 0;
    logic [31:0] m_addr = '0;

    always @(negedge clk) begin
        if (!reset_n) begin
            m_busy = 1'b0;
        end else begin
            if (m_busy) begin
                if (m_wait == 0) m_busy = 1'b0;
                else m_wait--;
            end
            if (imem_req && imem_gnt) begin
                m_busy = 1'b1;
                m_addr = imem_addr;
                m_wait = int'($urandom_range(lat_max, lat_min)) - 1;
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (force_stale) begin
            imem_rvalid = 1'b1;
            imem_rdata  = $urandom;
            imem_gnt    = 1'b0;
            force_stale = 1'b0;
        end else begin
            imem_rvalid = m_busy && (m_wait == 0);
            imem_rdata  = imem_rvalid ? ~m_addr : $urandom;
            imem_gnt    = ($urandom_range(99) < gnt_pct);
        end
        inst_ready = ($urandom_range(99) < ready_pct);
    end

    // Reference model: decode must see the program-order stream starting at
    // the reset PC or the latest redirect target, each word equal to ~pc.
    logic [31:0] e_pc, e_issue, hold_addr;
    int          occ = 0;
    bit          inflight = 1'b0, live = 1'b0, hold = 1'b0, after_rst = 1'b0;
    logic [31:0] pop_log[$];
    int          pop_cyc[$];

    always @(negedge clk) begin
        if (!reset_n) begin
            e_pc      = RST_PC;
            e_issue   = RST_PC;
            occ       = 0;
            inflight  = 1'b0;
            live      = 1'b0;
            hold      = 1'b0;
            after_rst = 1'b1;
        end else begin
            if (after_rst) begin
                check("rst_inst_valid", 32'(inst_valid), 32'd0);
                check("rst_imem_addr", imem_addr, RST_PC);
                check("rst_inst_pc", inst_pc, 32'd0);
                check("rst_inst_data", inst_data, 32'd0);
                after_rst = 1'b0;
            end
            check("inst_valid", 32'(inst_valid), 32'(occ > 0));
            if (redirect_valid) begin
                check("req_on_redirect", 32'(imem_req), 32'd0);
            end else if (hold) begin
                check("req_hold", 32'(imem_req), 32'd1);
                check("addr_hold", imem_addr, hold_addr);
            end
            if (inst_valid && inst_ready) begin
                check("inst_pc", inst_pc, e_pc);
                check("inst_data", inst_data, ~e_pc);
                pop_log.push_back(inst_pc);
                pop_cyc.push_back(cyc);
                e_pc = e_pc + 32'd4;
            end
            if (imem_req && imem_gnt) begin
                check("one_outstanding", 32'(inflight && !imem_rvalid), 32'd0);
                check("issue_addr", imem_addr, e_issue);
            end

            hold      = imem_req && !imem_gnt && !redirect_valid;
            hold_addr = imem_addr;
            if (redirect_valid) begin
                occ      = 0;
                e_pc     = redirect_pc & ~32'd3;
                e_issue  = e_pc;
                inflight = (inflight && !imem_rvalid) || (imem_req && imem_gnt);
                live     = 1'b0;
            end else begin
                if (imem_rvalid && inflight) begin
                    if (live) occ++;
                    inflight = 1'b0;
                    live     = 1'b0;
                end
                if (inst_valid && inst_ready && occ > 0) occ--;
                if (imem_req && imem_gnt) begin
                    inflight = 1'b1;
                    live     = 1'b1;
                    e_issue  = e_issue + 32'd4;
                end
            end
            check("occupancy_bound", 32'(occ <= DEPTH), 32'd1);
        end
    end

    function automatic logic [31:0] pop_at(input int i);
        if (i < pop_log.size()) return pop_log[i];
        return 32'hDEAD_BEE1;
    endfunction

    function automatic int pop_cyc_at(input int i);
        if (i < pop_cyc.size()) return pop_cyc[i];
        return -1;
    endfunction

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    int rel_cyc, n2, n4, n6;

    initial begin
        reset_n        = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = '0;
        imem_gnt       = 1'b0;
        imem_rvalid    = 1'b0;
        imem_rdata     = '0;
        inst_ready     = 1'b0;
        repeat (3) tick();

        // Fill from reset PC with wrap at 2^32, back-to-back delivery
        reset_n = 1'b1;
        rel_cyc = cyc;
        repeat (8) tick();
        check("t1_pc0", pop_at(0), 32'hFFFF_FFF8);
        check("t1_pc1", pop_at(1), 32'hFFFF_FFFC);
        check("t1_pc2", pop_at(2), 32'h0000_0000);
        check("t1_pc3", pop_at(3), 32'h0000_0004);
        for (int i = 0; i < 4; i++) check("t1_pop_cycle", 32'(pop_cyc_at(i)), 32'(rel_cyc + 2 + i));

        // Decode stalled: buffer fills to exactly two words and fetch stops
        ready_pct      = 0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0000;
        tick();
        redirect_valid = 1'b0;
        n2 = pop_log.size();
        repeat (10) tick();
        @(negedge clk);
        check("t2_valid", 32'(inst_valid), 32'd1);
        check("t2_head_pc", inst_pc, 32'h0000_0000);
        check("t2_req_low", 32'(imem_req), 32'd0);
        check("t2_model_occ", 32'(occ), 32'd2);
        check("t2_no_pop", 32'(pop_log.size()), 32'(n2));
        tick();
        gnt_pct   = 0;
        ready_pct = 100;
        repeat (6) tick();
        check("t2_drained", 32'(pop_log.size() - n2), 32'd2);
        check("t2_pc0", pop_at(n2), 32'h0000_0000);
        check("t2_pc1", pop_at(n2 + 1), 32'h0000_0004);

        // Grant withheld: request and address hold steady
        repeat (5) begin
            @(negedge clk);
            check("t3_req", 32'(imem_req), 32'd1);
            check("t3_addr", imem_addr, 32'h0000_0008);
        end
        tick();

        // Redirect while 0x8 is in flight
        gnt_pct = 100;
        lat_min = 3;
        lat_max = 3;
        tick();
        tick();
        redirect_valid = 1'b1;
        redirect_pc    = 32'h0000_0103;
        tick();
        redirect_valid = 1'b0;
        n4 = pop_log.size();
        @(negedge clk);
        check("t4_discard_req0", 32'(imem_req), 32'd0);
        @(negedge clk);
        check("t4_discard_req1", 32'(imem_req), 32'd0);
        repeat (12) tick();
        check("t4_pc0", pop_at(n4), 32'h0000_0100);
        check("t4_pc1", pop_at(n4 + 1), 32'h0000_0104);

        // Random traffic with random redirects
        for (int k = 0; k < 2000; k++) begin
            if (k % 200 == 0) begin
                gnt_pct   = int'($urandom_range(100, 30));
                ready_pct = int'($urandom_range(100, 20));
                lat_min   = 1;
                lat_max   = int'($urandom_range(4, 1));
            end
            redirect_valid = ($urandom_range(99) < 4);
            case ($urandom_range(2))
                0:       redirect_pc = $urandom;
                1:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(15));
                default: redirect_pc = 32'($urandom_range(255));
            endcase
            tick();
        end
        redirect_valid = 1'b0;

        // One-cycle reset with a full buffer, plus a stale response after release
        gnt_pct   = 100;
        ready_pct = 0;
        lat_min   = 1;
        lat_max   = 1;
        repeat (12) tick();
        @(negedge clk);
        check("t6_full_before", 32'(inst_valid), 32'd1);
        tick();
        reset_n     = 1'b0;
        force_stale = 1'b1;
        ready_pct   = 100;
        tick();
        reset_n = 1'b1;
        n6 = pop_log.size();
        @(negedge clk);
        check("t6_valid_low", 32'(inst_valid), 32'd0);
        check("t6_addr", imem_addr, RST_PC);
        repeat (8) tick();
        check("t6_first_pc", pop_at(n6), RST_PC);
        check("t6_second_pc", pop_at(n6 + 1), 32'hFFFF_FFFC);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish (cycle %0d)", cyc);
        $fatal(1);
    end

endmodule
